// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the write-back unit: FSM state encoding and load funct3 codes.
package ysyx_24110006_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wbu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/ysyx_24110006_load_align.sv
// Formats an aligned 32-bit memory word into the load result selected by funct3 and addr_lo.
module ysyx_24110006_load_align
  import ysyx_24110006_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] formatted
);

  logic [31:0] shifted;

  // Misaligned halfwords simply take whatever bits the shift leaves behind.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      LB:      formatted = {{24{shifted[7]}}, shifted[7:0]};
      LH:      formatted = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     formatted = {24'b0, shifted[7:0]};
      LHU:     formatted = {16'b0, shifted[15:0]};
      default: formatted = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_wbu.sv
// Write-back unit: accepts one retiring instruction, waits for load data, issues one regfile write.
// Optional retired-instruction counter o_instret when YSYX_24110006_WBU_INSTRET_EN is defined.
module ysyx_24110006_wbu
  import ysyx_24110006_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_pc,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic                  i_wen,
  input  logic                  i_is_load,
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr_lo,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
`ifdef YSYX_24110006_WBU_INSTRET_EN
  output logic [63:0]           o_instret,
`endif
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic                  o_wen,
  output logic [31:0]           o_pc
);

  wbu_state_e  state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] load_data;

  ysyx_24110006_load_align u_load_align (
    .rdata     (i_mem_rdata),
    .funct3    (funct3_q),
    .addr_lo   (addr_lo_q),
    .formatted (load_data)
  );

  assign o_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      o_valid   <= 1'b0;
      o_wdata   <= '0;
      o_waddr   <= '0;
      o_wen     <= 1'b0;
      o_pc      <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            o_pc      <= i_pc;
            o_waddr   <= i_rd;
            o_wen     <= i_wen;
            funct3_q  <= i_funct3;
            addr_lo_q <= i_addr_lo;
            if (i_is_load) begin
              state <= WAIT_MEM;
            end else begin
              o_wdata <= i_result;
              o_valid <= 1'b1;
              state   <= COMMIT;
            end
          end
        end
        WAIT_MEM: begin
          if (i_mem_rvalid) begin
            o_wdata <= load_data[DATA_WIDTH-1:0];
            o_valid <= 1'b1;
            state   <= COMMIT;
          end
        end
        COMMIT: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef YSYX_24110006_WBU_INSTRET_EN
  // Counts every commit, including those that do not write rd; wraps naturally.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_instret <= '0;
    end else if (state == COMMIT) begin
      o_instret <= o_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24110006_wbu.sv
// Self-checking bench for ysyx_24110006_wbu: table-driven vectors plus multi-cycle corner sequences.
module tb_ysyx_24110006_wbu;
  import ysyx_24110006_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [31:0] i_result;
  logic [4:0]  i_rd;
  logic        i_wen;
  logic        i_is_load;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lo;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_valid;
  logic [31:0] o_wdata;
  logic [4:0]  o_waddr;
  logic        o_wen;
  logic [31:0] o_pc;
`ifdef YSYX_24110006_WBU_INSTRET_EN
  logic [63:0] o_instret;
`endif

  int checks   = 0;
  int failures = 0;

  ysyx_24110006_wbu dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_pc         (i_pc),
    .i_result     (i_result),
    .i_rd         (i_rd),
    .i_wen        (i_wen),
    .i_is_load    (i_is_load),
    .i_funct3     (i_funct3),
    .i_addr_lo    (i_addr_lo),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
`ifdef YSYX_24110006_WBU_INSTRET_EN
    .o_instret    (o_instret),
`endif
    .o_valid      (o_valid),
    .o_wdata      (o_wdata),
    .o_waddr      (o_waddr),
    .o_wen        (o_wen),
    .o_pc         (o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] result;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] pc;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_instr(input vec_t v);
    i_valid   = 1'b1;
    i_is_load = v.is_load;
    i_funct3  = v.funct3;
    i_addr_lo = v.addr_lo;
    i_result  = v.result;
    i_rd      = v.rd;
    i_wen     = v.wen;
    i_pc      = v.pc;
  endtask

  task automatic idle_inputs();
    i_valid      = 1'b0;
    i_is_load    = 1'b0;
    i_funct3     = 3'b0;
    i_addr_lo    = 2'b0;
    i_result     = 32'h0;
    i_rd         = 5'h0;
    i_wen        = 1'b0;
    i_pc         = 32'h0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'h0;
  endtask

  task automatic check_commit(input string tag, input vec_t v);
    check({tag, "_valid"}, 64'(o_valid), 64'd1);
    check({tag, "_ready"}, 64'(o_ready), 64'd0);
    check({tag, "_wdata"}, 64'(o_wdata), 64'(v.exp_wdata));
    check({tag, "_waddr"}, 64'(o_waddr), 64'(v.rd));
    check({tag, "_wen"},   64'(o_wen),   64'(v.wen));
    check({tag, "_pc"},    64'(o_pc),    64'(v.pc));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the commit.
  task automatic run_vec(input string tag, input vec_t v);
    check({tag, "_ready_pre"}, 64'(o_ready), 64'd1);
    drive_instr(v);
    @(negedge clk);
    idle_inputs();
    if (v.is_load) begin
      check({tag, "_wait_valid"}, 64'(o_valid), 64'd0);
      check({tag, "_wait_ready"}, 64'(o_ready), 64'd0);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = v.rdata;
      @(negedge clk);
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'h0;
    end
    check_commit(tag, v);
    @(negedge clk);
    check({tag, "_valid_post"}, 64'(o_valid), 64'd0);
    check({tag, "_ready_post"}, 64'(o_ready), 64'd1);
  endtask

  vec_t vecs[12];
  vec_t v;

  initial begin
    //          load  f3    lo    result        rdata         rd     wen   pc            expected
    vecs[0]  = '{1'b0, LW,   2'd0, 32'hDEADBEEF, 32'h0,        5'd5,  1'b1, 32'h8000_0000, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, LB,   2'd1, 32'h0,        32'h80FF7F01, 5'd1,  1'b1, 32'h8000_0004, 32'h0000007F};
    vecs[2]  = '{1'b1, LB,   2'd2, 32'h0,        32'h80FF7F01, 5'd2,  1'b1, 32'h8000_0008, 32'hFFFFFFFF};
    vecs[3]  = '{1'b1, LBU,  2'd3, 32'h0,        32'h80FF7F01, 5'd3,  1'b1, 32'h8000_000C, 32'h00000080};
    vecs[4]  = '{1'b1, LH,   2'd2, 32'h0,        32'h80011234, 5'd4,  1'b1, 32'h8000_0010, 32'hFFFF8001};
    vecs[5]  = '{1'b1, LHU,  2'd2, 32'h0,        32'h80011234, 5'd6,  1'b1, 32'h8000_0014, 32'h00008001};
    vecs[6]  = '{1'b1, LH,   2'd3, 32'h0,        32'h80011234, 5'd7,  1'b1, 32'h8000_0018, 32'h00000080};
    vecs[7]  = '{1'b1, LW,   2'd0, 32'h0,        32'h80011234, 5'd8,  1'b1, 32'h8000_001C, 32'h80011234};
    vecs[8]  = '{1'b0, LB,   2'd1, 32'h12345678, 32'h0,        5'd0,  1'b0, 32'h8000_0020, 32'h12345678};
    vecs[9]  = '{1'b1, 3'b011, 2'd0, 32'h0,      32'hCAFEBABE, 5'd15, 1'b1, 32'h8000_0024, 32'hCAFEBABE};
    vecs[10] = '{1'b1, LB,   2'd0, 32'h0,        32'h80FF7F01, 5'd10, 1'b1, 32'h8000_0028, 32'h00000001};
    vecs[11] = '{1'b1, LHU,  2'd0, 32'h0,        32'h80011234, 5'd11, 1'b0, 32'h8000_002C, 32'h00001234};

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_wdata", 64'(o_wdata), 64'd0);
    check("rst_waddr", 64'(o_waddr), 64'd0);
    check("rst_wen",   64'(o_wen),   64'd0);
    check("rst_pc",    64'(o_pc),    64'd0);
`ifdef YSYX_24110006_WBU_INSTRET_EN
    check("rst_instret", o_instret, 64'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Delayed load response, with an rvalid in the acceptance cycle that must be ignored.
    v = '{1'b1, LW, 2'd0, 32'h0, 32'h0BADF00D, 5'd9, 1'b1, 32'h0000_1234, 32'h0BADF00D};
    drive_instr(v);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 7; c++) begin
      check($sformatf("delay%0d_valid", c), 64'(o_valid), 64'd0);
      check($sformatf("delay%0d_ready", c), 64'(o_ready), 64'd0);
      @(negedge clk);
    end
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = v.rdata;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'h0;
    check_commit("delay_commit", v);
    @(negedge clk);
    check("delay_valid_post", 64'(o_valid), 64'd0);

    // Spurious responses while idle must not produce a write.
    for (int c = 0; c < 3; c++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h5555_AAAA;
      @(negedge clk);
      check($sformatf("spurious%0d_valid", c), 64'(o_valid), 64'd0);
      check($sformatf("spurious%0d_ready", c), 64'(o_ready), 64'd1);
    end
    idle_inputs();

    // Reset while waiting for memory abandons the instruction.
    v = '{1'b1, LW, 2'd0, 32'h0, 32'h7777_7777, 5'd12, 1'b1, 32'h0000_4444, 32'h7777_7777};
    drive_instr(v);
    @(negedge clk);
    idle_inputs();
    check("abort_wait_ready", 64'(o_ready), 64'd0);
    rst = 1'b1;
    drive_instr(v);
    @(negedge clk);
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_ready", 64'(o_ready), 64'd1);
    check("abort_wdata", 64'(o_wdata), 64'd0);
    check("abort_waddr", 64'(o_waddr), 64'd0);
    check("abort_wen",   64'(o_wen),   64'd0);
    check("abort_pc",    64'(o_pc),    64'd0);
`ifdef YSYX_24110006_WBU_INSTRET_EN
    check("abort_instret", o_instret, 64'd0);
`endif
    // Held valid during reset must not be accepted.
    @(negedge clk);
    check("rst_hold_ready", 64'(o_ready), 64'd1);
    rst = 1'b0;
    idle_inputs();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h7777_7777;
    @(negedge clk);
    check("post_rst_valid", 64'(o_valid), 64'd0);
    check("post_rst_ready", 64'(o_ready), 64'd1);
    idle_inputs();

    // Three commits after reset, one without a register write.
    run_vec("post0", vecs[0]);
    run_vec("post1", vecs[8]);
    run_vec("post2", vecs[4]);
`ifdef YSYX_24110006_WBU_INSTRET_EN
    check("instret3", o_instret, 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_wbu.md
# ysyx_24110006_wbu

Write-back unit of the multi-cycle NPC core, sitting between the execute/load-store side and the 16-entry RV32E register file. It accepts one retiring instruction at a time from the EXU, waits for load data from the LSU when needed, and formats sub-word loads. It then issues exactly one single-cycle write request (data, rd, enable, valid) to the register file.

## Interface
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 5, rd address width; the register file uses only the low 4 bits.
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_valid  in  1  EXU has a retiring instruction.
- o_ready  out  1  WBU can accept (high only in IDLE).
- i_pc  in  32  PC of the retiring instruction.
- i_result  in  DATA_WIDTH  ALU/CSR/link result, used for non-loads.
- i_rd  in  ADDR_WIDTH  destination register.
- i_wen  in  1  instruction writes rd.
- i_is_load  in  1  result comes from memory.
- i_funct3  in  3  load type.
- i_addr_lo  in  2  low bits of the load effective address.
- i_mem_rvalid  in  1  LSU read data valid (single-cycle pulse).
- i_mem_rdata  in  32  LSU read data, the aligned 32-bit word.
- o_valid  out  1  write request to the register file, one-cycle pulse.
- o_wdata  out  DATA_WIDTH  write data.
- o_waddr  out  ADDR_WIDTH  write address.
- o_wen  out  1  write enable.
- o_pc  out  32  PC of the committing instruction, for difftest/trace.

## Operation
- FSM states: IDLE, WAIT_MEM, COMMIT.
- IDLE:
  - o_ready=1.
  - A handshake (i_valid && o_ready && !i_reset) latches pc, rd, wen, funct3 and addr_lo.
  - Non-load: latch i_result as wdata and go to COMMIT.
  - Load: go to WAIT_MEM.
- WAIT_MEM:
  - o_ready=0.
  - On i_mem_rvalid, latch the formatted load data as wdata and go to COMMIT.
  - Stay in WAIT_MEM indefinitely otherwise; there is no timeout.
- COMMIT:
  - o_valid=1, with o_wdata, o_waddr, o_wen and o_pc driven from the latched values.
  - Next cycle: return to IDLE.
- i_mem_rvalid outside WAIT_MEM is ignored.
- rd=0 is forwarded unchanged; the register file performs the x0 masking.
- Load formatting: shifted = i_mem_rdata >> (8*addr_lo).
  - 000 LB: sign-extend shifted[7:0].
  - 001 LH: sign-extend shifted[15:0].
  - 100 LBU: zero-extend shifted[7:0].
  - 101 LHU: zero-extend shifted[15:0].
  - 010 LW and every other code: shifted.
  - Misalignment is not checked. Example: LH at addr_lo=3 yields {24'b0, byte3}, whose sign bit is 0, so the result is zero-extended.
- Reset values: state IDLE; o_valid 0; o_wdata, o_waddr, o_wen, o_pc all 0; all latched fields 0.
- o_ready reads 1 during reset, but no acceptance occurs while i_reset=1.
- Reset mid-operation (WAIT_MEM or COMMIT): abandon the instruction, no write is issued, return to IDLE next cycle.

## Timing
- Non-load: accept at cycle N, o_valid at N+1, o_ready high again at N+2. Throughput is one instruction per 2 cycles.
- Load: accept at N; i_mem_rvalid at M≥N+1; o_valid at M+1.
- i_mem_rvalid arriving in the same cycle as acceptance is ignored; the LSU must respond at least one cycle after acceptance.
- All outputs except o_ready are registered. o_ready is a combinational decode of state.
- Register-file write lands on the edge ending the COMMIT cycle.

## Configuration
- YSYX_24110006_WBU_INSTRET_EN defined:
  - Adds output o_instret (64 bits).
  - Resets to 0 and increments by 1 on every COMMIT cycle, including commits with wen=0.
  - Wraps from all-ones to 0.
- Undefined: neither the port nor the counter exists; behaviour is otherwise identical.

## Structure
- Shared package ysyx_24110006_pkg holds:
  - the FSM state encoding (IDLE=0, WAIT_MEM=1, COMMIT=2, 2 bits);
  - the load funct3 constants LB, LH, LW, LBU, LHU.
- One combinational sub-module, ysyx_24110006_load_align (inputs rdata, funct3, addr_lo; output formatted word), instantiated once in the WBU.

## Test plan
- Non-load: i_result=0xDEADBEEF, rd=5, wen=1 accepted at N → o_valid=1 only at N+1 with o_wdata=0xDEADBEEF, o_waddr=5, o_wen=1; o_ready=0 at N+1, 1 at N+2.
- LB with rdata=0x80FF7F01:
  - addr_lo=1 → wdata=0x0000007F;
  - addr_lo=2 → wdata=0xFFFFFFFF;
  - LBU at addr_lo=3 → wdata=0x00000080.
- LH / LHU with rdata=0x8001_1234:
  - LH at addr_lo=2 → wdata=0xFFFF8001;
  - LHU at addr_lo=2 → wdata=0x00008001;
  - LH at addr_lo=3 → wdata=0x00000080.
- Load with i_mem_rvalid delayed 7 cycles → o_ready=0 and o_valid=0 throughout the wait. o_valid pulses exactly once, at rvalid+1, carrying the latched rd and pc. A spurious i_mem_rvalid in IDLE causes no write.
- Reset asserted while in WAIT_MEM → no o_valid is ever issued; state is IDLE with all outputs 0 one cycle after reset. A new instruction is accepted right after reset deasserts.
- With YSYX_24110006_WBU_INSTRET_EN defined: 3 commits, including one with wen=0 → o_instret=3. An instruction abandoned by reset does not increment the counter.
